// File: rtl/transmitter_if.sv
// transmitter_if -- host-side bundle for the serial transmitter.
//   dataIn            : parallel data word from the host
//   host_write        : single-cycle write strobe, dataIn valid this cycle
//   host_acknowledged : host has seen host_interrupt
//   dataOut           : serial line, idle high
//   host_interrupt    : holding register empty, host may write
//   tx_busy           : a frame is on the line
//   err               : sticky overrun flag
// master = host side, slave = transmitter side.
interface transmitter_if;
  logic [7:0] dataIn;
  logic       host_write;
  logic       host_acknowledged;
  logic       dataOut;
  logic       host_interrupt;
  logic       tx_busy;
  logic       err;

  modport master (
    output dataIn, host_write, host_acknowledged,
    input  dataOut, host_interrupt, tx_busy, err
  );

  modport slave (
    input  dataIn, host_write, host_acknowledged,
    output dataOut, host_interrupt, tx_busy, err
  );
endinterface

// File: rtl/transmitter.sv
// transmitter -- oversampled asynchronous serial transmitter.
// Frame: start(0), 8 data bits LSB first, parity, STOP_BITS stop bits(1).
// Each bit lasts OVERSAMPLE overSampler cycles. A holding register in front
// of the shift register allows back-to-back frames without idle gaps.
//   overSampler : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : host handshake and serial output (transmitter_if.slave)
module transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_ODD = 0
) (
  input logic          overSampler,
  input logic          reset_n,
  transmitter_if.slave bus
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Parity over the data byte; odd selection inverts the even result.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    parity_bit = (^d) ^ odd;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          irq_q, irq_d;
  logic          err_q, err_d;
  logic          ack_q;
  logic          bit_end_s;
  logic          xfer_s;
  logic          ack_rise_s;

  // Next-state logic: bit timing, frame sequencing, holding register, flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    irq_d       = irq_q;
    err_d       = err_q;
    xfer_s      = 1'b0;
    bit_end_s   = (cnt_q == CNT_LAST);
    // Only a fresh acknowledge clears the interrupt, so a held level
    // cannot swallow a later set.
    ack_rise_s  = bus.host_acknowledged & ~ack_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (bit_end_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          xfer_s  = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          idx_d   = 3'd0;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          idx_d = 3'd0;
          if (idx_q != STOP_LAST) begin
            idx_d = idx_q + 3'd1;
          end else if (hold_full_q) begin
            // Chain straight into the next start bit.
            xfer_s  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase

    if (xfer_s) begin
      shift_d  = hold_q;
      parity_d = parity_bit(hold_q, PARITY_ODD[0]);
    end else begin
      parity_d = parity_q;
    end

    // A write coinciding with a transfer refills the register the
    // transfer is emptying; otherwise a write into a full one is an overrun.
    if (bus.host_write) begin
      if (!hold_full_q || xfer_s) begin
        hold_d      = bus.dataIn;
        hold_full_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (xfer_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    if (xfer_s) begin
      irq_d = 1'b1;
    end else if (ack_rise_s || bus.host_write) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Line level decoded from the current state, registered so dataOut is glitch-free.
  always_comb begin
    dout_d = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE:    dout_d = 1'b1;
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_q[0];
      PARITY:  dout_d = parity_q;
      STOP:    dout_d = 1'b1;
      default: dout_d = 1'b1;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge overSampler or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      dout_q      <= 1'b1;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      ack_q       <= bus.host_acknowledged;
    end
  end

  assign bus.dataOut        = dout_q;
  assign bus.tx_busy        = busy_q;
  assign bus.host_interrupt = irq_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter -- directed bench for transmitter. Two instances: u_even
// with default parameters and u_odd with PARITY_ODD=1 (only used for parity).
module tb_transmitter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  transmitter_if if1 ();
  transmitter_if if2 ();

  transmitter #(.OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(0)) u_even (
    .overSampler(clk), .reset_n(reset_n), .bus(if1.slave));
  transmitter #(.OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(1)) u_odd (
    .overSampler(clk), .reset_n(reset_n), .bus(if2.slave));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [7:0] d);
    if1.dataIn = d;
    if1.host_write = 1'b1;
    tick();
    if1.host_write = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  // Checks a frame starting at the current cycle (start bit visible now):
  // first and last cycle of every bit. exp bit i = i-th bit on the line.
  task automatic expect_frame(input logic [11:0] exp1, input logic [11:0] exp2,
                              input bit chk2, input string name, output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 16; c++) begin
        if (if1.tx_busy === 1'b1) busy_cycles++;
        if (c == 0 || c == 15) begin
          n_cmp++;
          if (if1.dataOut !== exp1[k]) begin
            n_bad++;
            $display("FAIL %s bit%0d cyc%0d: dataOut=%b expected=%b", name, k, c, if1.dataOut, exp1[k]);
          end
          if (chk2) begin
            n_cmp++;
            if (if2.dataOut !== exp2[k]) begin
              n_bad++;
              $display("FAIL %s odd bit%0d cyc%0d: dataOut=%b expected=%b", name, k, c, if2.dataOut, exp2[k]);
            end
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({if1.dataOut, if1.tx_busy, if1.host_interrupt, if1.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset: {dout,busy,irq,err}=%b expected=1000",
               {if1.dataOut, if1.tx_busy, if1.host_interrupt, if1.err});
    end
    n_cmp++;
    if ({if2.dataOut, if2.tx_busy, if2.host_interrupt, if2.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_odd: {dout,busy,irq,err}=%b expected=1000",
               {if2.dataOut, if2.tx_busy, if2.host_interrupt, if2.err});
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_frame;
    int busy;
    write1(8'hA5);
    n_cmp++;
    if ({if1.dataOut, if1.tx_busy, if1.host_interrupt} !== 3'b100) begin
      n_bad++;
      $display("FAIL latency_n: {dout,busy,irq}=%b expected=100",
               {if1.dataOut, if1.tx_busy, if1.host_interrupt});
    end
    tick();
    n_cmp++;
    if ({if1.dataOut, if1.tx_busy, if1.host_interrupt} !== 3'b111) begin
      n_bad++;
      $display("FAIL latency_n1: {dout,busy,irq}=%b expected=111",
               {if1.dataOut, if1.tx_busy, if1.host_interrupt});
    end
    tick();
    expect_frame(12'hD4A, 12'h000, 1'b0, "frame_a5", busy);
    n_cmp++;
    if (busy + 1 !== 192) begin
      n_bad++;
      $display("FAIL busy_cycles: got=%0d expected=192", busy + 1);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (if1.dataOut !== 1'b1 || if1.tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_a5 cyc%0d: dout=%b busy=%b expected 1/0", i, if1.dataOut, if1.tx_busy);
      end
      tick();
    end
  endtask

  task automatic test_parity;
    int busy;
    if1.dataIn = 8'h01; if1.host_write = 1'b1;
    if2.dataIn = 8'h01; if2.host_write = 1'b1;
    tick();
    if1.host_write = 1'b0;
    if2.host_write = 1'b0;
    tick();
    tick();
    expect_frame(12'hE02, 12'hC02, 1'b1, "parity_01", busy);
    repeat (4) tick();
  endtask

  task automatic test_back_to_back;
    int busy;
    write1(8'h55);
    tick();
    n_cmp++;
    if (if1.host_interrupt !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_irq1: host_interrupt=%b expected=1", if1.host_interrupt);
    end
    write1(8'hF0);
    n_cmp++;
    if (if1.host_interrupt !== 1'b0 || if1.err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_write: irq=%b err=%b expected 0/0", if1.host_interrupt, if1.err);
    end
    expect_frame(12'hCAA, 12'h000, 1'b0, "b2b_55", busy);
    expect_frame(12'hDE0, 12'h000, 1'b0, "b2b_f0", busy);
    n_cmp++;
    if (if1.host_interrupt !== 1'b1 || if1.err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_irq2: irq=%b err=%b expected 1/0", if1.host_interrupt, if1.err);
    end
    repeat (4) tick();
  endtask

  task automatic test_overrun;
    int busy;
    write1(8'h11);
    write1(8'h22);
    write1(8'h33);
    n_cmp++;
    if (if1.err !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_err: err=%b expected=1", if1.err);
    end
    expect_frame(12'hC22, 12'h000, 1'b0, "ovr_11", busy);
    expect_frame(12'hC44, 12'h000, 1'b0, "ovr_22", busy);
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (if1.dataOut !== 1'b1 || if1.tx_busy !== 1'b0 || if1.err !== 1'b1) begin
        n_bad++;
        $display("FAIL ovr_dropped cyc%0d: dout=%b busy=%b err=%b expected 1/0/1",
                 i, if1.dataOut, if1.tx_busy, if1.err);
      end
      tick();
    end
  endtask

  task automatic test_handshake;
    int i;
    write1(8'h5A);
    tick();
    n_cmp++;
    if (if1.host_interrupt !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_set: host_interrupt=%b expected=1", if1.host_interrupt);
    end
    if1.host_acknowledged = 1'b1;
    tick();
    if1.host_acknowledged = 1'b0;
    n_cmp++;
    if (if1.host_interrupt !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_ack_clear: host_interrupt=%b expected=0", if1.host_interrupt);
    end
    write1(8'h3C);
    if1.host_acknowledged = 1'b1;
    repeat (189) tick();
    n_cmp++;
    if (if1.host_interrupt !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_pre_xfer: host_interrupt=%b expected=0", if1.host_interrupt);
    end
    tick();
    n_cmp++;
    if (if1.host_interrupt !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_set_wins: host_interrupt=%b expected=1", if1.host_interrupt);
    end
    repeat (5) tick();
    if1.host_acknowledged = 1'b0;
    tick();
    n_cmp++;
    if (if1.host_interrupt !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_level_held: host_interrupt=%b expected=1", if1.host_interrupt);
    end
    if1.host_acknowledged = 1'b1;
    tick();
    if1.host_acknowledged = 1'b0;
    n_cmp++;
    if (if1.host_interrupt !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_new_ack: host_interrupt=%b expected=0", if1.host_interrupt);
    end
    i = 0;
    while (i < 400 && if1.tx_busy === 1'b1) begin
      tick();
      i++;
    end
    n_cmp++;
    if (if1.tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_timeout: tx_busy=%b expected=0 within 400 cycles", if1.tx_busy);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_frame;
    int busy;
    write1(8'h96);
    tick();
    write1(8'h0F);
    repeat (69) tick();
    n_cmp++;
    if (if1.dataOut !== 1'b0 || if1.tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_bit3: dout=%b busy=%b expected 0/1", if1.dataOut, if1.tx_busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({if1.dataOut, if1.tx_busy, if1.host_interrupt, if1.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_reset_async: {dout,busy,irq,err}=%b expected=1000",
               {if1.dataOut, if1.tx_busy, if1.host_interrupt, if1.err});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (if1.dataOut !== 1'b1 || if1.tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_discard cyc%0d: dout=%b busy=%b expected 1/0", i, if1.dataOut, if1.tx_busy);
      end
    end
    write1(8'h3C);
    tick();
    tick();
    expect_frame(12'hC78, 12'h000, 1'b0, "post_reset_3c", busy);
  endtask

  initial begin
    reset_n = 1'b0;
    if1.dataIn = 8'h00; if1.host_write = 1'b0; if1.host_acknowledged = 1'b0;
    if2.dataIn = 8'h00; if2.host_write = 1'b0; if2.host_acknowledged = 1'b0;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_overrun();
    test_handshake();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
